// File: rtl/cmd_sequencer_pkg.sv
// Shared types and constants for the command sequencer: opcode and FSM state
// encodings plus default response bytes.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    OP_CAL   = 3'b000,
    OP_HDNG  = 3'b001,
    OP_MOVE  = 3'b010,
    OP_SOLVE = 3'b011
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    HDNG,
    MOVE,
    WAIT_CAL,
    WAIT_MV,
    SEND,
    WAIT_TX
  } state_e;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] NAK_DEFAULT = 8'h5A;

  // Opcodes 100..111 have no enum member and fall to the default decode arm.
  function automatic opcode_e cmd_opcode(input logic [15:0] cmd);
    return opcode_e'(cmd[15:13]);
  endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Command/response handshake and maze-runner action bus between the UART
// command wrapper / datapath (slave side) and the sequencer (master side).
interface cmd_sequencer_if;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;
  logic        strt_cal;
  logic        cal_done;
  logic        strt_hdng;
  logic        strt_mv;
  logic        mv_cmplt;
  logic [11:0] dsrd_hdng;
  logic        stp_lft;
  logic        stp_rght;
  logic        cmd_md;
  logic        lft_rght;

  modport master (
    input  cmd, cmd_rdy, tx_done, cal_done, mv_cmplt,
    output clr_cmd_rdy, trmt, resp, strt_cal, strt_hdng, strt_mv,
           dsrd_hdng, stp_lft, stp_rght, cmd_md, lft_rght
  );

  modport slave (
    output cmd, cmd_rdy, tx_done, cal_done, mv_cmplt,
    input  clr_cmd_rdy, trmt, resp, strt_cal, strt_hdng, strt_mv,
           dsrd_hdng, stp_lft, stp_rght, cmd_md, lft_rght
  );

endinterface

// File: rtl/cmd_sequencer.sv
// Decodes one UART command at a time, launches the datapath action, waits for
// its completion and returns an ACK/NAK byte. CMD_TMO_EN adds a wait timeout.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
`ifdef CMD_TMO_EN
  parameter int         TMO_W    = 24,
`endif
  parameter logic [7:0] ACK_BYTE = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE = NAK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  cmd_sequencer_if.master  bus
);

  state_e      state_q, state_d;
  logic [7:0]  resp_q, resp_d;
  logic [11:0] hdng_q, hdng_d;
  logic        stp_lft_q, stp_lft_d;
  logic        stp_rght_q, stp_rght_d;
  logic        cmd_md_q, cmd_md_d;
  logic        lft_rght_q, lft_rght_d;
  logic        trmt_q, trmt_d;
  logic        clr_cmd_rdy;
  logic        strt_cal, strt_hdng, strt_mv;
  logic        tmo_expired;
  logic        unused_cmd_bit;

  assign unused_cmd_bit = bus.cmd[12];

`ifdef CMD_TMO_EN
  logic [TMO_W-1:0] tmo_cnt_q;

  // Cleared in the start-pulse state so it reads 0 on the first wait cycle;
  // saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == CAL || state_q == HDNG || state_q == MOVE) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == WAIT_CAL || state_q == WAIT_MV) && !tmo_expired) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_expired = &tmo_cnt_q;
`else
  assign tmo_expired = 1'b0;
`endif

  // NOTE: every variable gets its default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    hdng_d      = hdng_q;
    stp_lft_d   = stp_lft_q;
    stp_rght_d  = stp_rght_q;
    cmd_md_d    = cmd_md_q;
    lft_rght_d  = lft_rght_q;
    trmt_d      = 1'b0;
    clr_cmd_rdy = 1'b0;
    strt_cal    = 1'b0;
    strt_hdng   = 1'b0;
    strt_mv     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Gated by rst so a pending command is not consumed while resetting.
        if (bus.cmd_rdy && !rst) begin
          clr_cmd_rdy = 1'b1;
          case (cmd_opcode(bus.cmd))
            OP_CAL: begin
              cmd_md_d = 1'b1;
              state_d  = CAL;
            end
            OP_HDNG: begin
              hdng_d   = bus.cmd[11:0];
              cmd_md_d = 1'b1;
              state_d  = HDNG;
            end
            OP_MOVE: begin
              stp_lft_d  = bus.cmd[1];
              stp_rght_d = bus.cmd[0];
              cmd_md_d   = 1'b1;
              state_d    = MOVE;
            end
            OP_SOLVE: begin
              cmd_md_d   = 1'b0;
              lft_rght_d = bus.cmd[0];
              resp_d     = ACK_BYTE;
              state_d    = SEND;
            end
            default: begin
              resp_d  = NAK_BYTE;
              state_d = SEND;
            end
          endcase
        end
      end
      CAL: begin
        strt_cal = 1'b1;
        state_d  = WAIT_CAL;
      end
      HDNG: begin
        strt_hdng = 1'b1;
        state_d   = WAIT_MV;
      end
      MOVE: begin
        strt_mv = 1'b1;
        state_d = WAIT_MV;
      end
      WAIT_CAL: begin
        if (bus.cal_done) begin
          resp_d  = ACK_BYTE;
          state_d = SEND;
        end else if (tmo_expired) begin
          resp_d  = NAK_BYTE;
          state_d = SEND;
        end
      end
      WAIT_MV: begin
        if (bus.mv_cmplt) begin
          resp_d  = ACK_BYTE;
          state_d = SEND;
        end else if (tmo_expired) begin
          resp_d  = NAK_BYTE;
          state_d = SEND;
        end
      end
      SEND: begin
        // trmt is registered, landing one cycle after SEND.
        trmt_d  = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      resp_q     <= ACK_BYTE;
      hdng_q     <= '0;
      stp_lft_q  <= 1'b0;
      stp_rght_q <= 1'b0;
      cmd_md_q   <= 1'b1;
      lft_rght_q <= 1'b0;
      trmt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_q     <= resp_d;
      hdng_q     <= hdng_d;
      stp_lft_q  <= stp_lft_d;
      stp_rght_q <= stp_rght_d;
      cmd_md_q   <= cmd_md_d;
      lft_rght_q <= lft_rght_d;
      trmt_q     <= trmt_d;
    end
  end

  assign bus.clr_cmd_rdy = clr_cmd_rdy;
  assign bus.trmt        = trmt_q;
  assign bus.resp        = resp_q;
  assign bus.strt_cal    = strt_cal;
  assign bus.strt_hdng   = strt_hdng;
  assign bus.strt_mv     = strt_mv;
  assign bus.dsrd_hdng   = hdng_q;
  assign bus.stp_lft     = stp_lft_q;
  assign bus.stp_rght    = stp_rght_q;
  assign bus.cmd_md      = cmd_md_q;
  assign bus.lft_rght    = lft_rght_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomized self-checking bench for cmd_sequencer against a transaction-level
// model; define CMD_TMO_EN to build with a 4-bit timeout.
module tb_cmd_sequencer;
  import cmd_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_sequencer_if bus();

`ifdef CMD_TMO_EN
  localparam int TMO_W   = 4;
  localparam int TMO_MAX = (1 << TMO_W) - 1;
  cmd_sequencer #(.TMO_W(TMO_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  cmd_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  // Model of the registered outputs.
  logic [11:0] m_hdng;
  logic        m_stp_l, m_stp_r, m_md, m_lr;
  logic [7:0]  m_resp;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pulse vector order: {clr_cmd_rdy, trmt, strt_cal, strt_hdng, strt_mv}
  task automatic chk_pulses(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, bus.clr_cmd_rdy, bus.trmt, bus.strt_cal, bus.strt_hdng, bus.strt_mv},
          {27'd0, exp});
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_regs"},
          {16'd0, bus.dsrd_hdng, bus.stp_lft, bus.stp_rght, bus.cmd_md, bus.lft_rght},
          {16'd0, m_hdng, m_stp_l, m_stp_r, m_md, m_lr});
  endtask

  task automatic model_reset();
    m_hdng  = 12'h000;
    m_stp_l = 1'b0;
    m_stp_r = 1'b0;
    m_md    = 1'b1;
    m_lr    = 1'b0;
    m_resp  = 8'hA5;
  endtask

  task automatic clear_strobes();
    bus.cal_done = 1'b0;
    bus.mv_cmplt = 1'b0;
  endtask

  task automatic drive_strobe(input bit is_cal, input bit matching, input logic v);
    if (is_cal == matching) bus.cal_done = v;
    else                    bus.mv_cmplt = v;
  endtask

  // Accepts command c (cmd_rdy raised on entry) and returns the expected
  // start-pulse vector after updating the model.
  task automatic accept(input logic [15:0] c, output logic [4:0] exp_start, output bit action);
    @(negedge clk);
    rst          = 1'b0;
    bus.cmd      = c;
    bus.cmd_rdy  = 1'b1;
    bus.tx_done  = 1'b0;
    clear_strobes();
    #1;
    chk_pulses("accept", 5'b10000);
    check_regs("pre_accept");
    action    = 1'b1;
    exp_start = 5'b00000;
    case (c[15:13])
      3'd0: begin m_md = 1'b1; exp_start = 5'b00100; end
      3'd1: begin m_hdng = c[11:0]; m_md = 1'b1; exp_start = 5'b00010; end
      3'd2: begin m_stp_l = c[1]; m_stp_r = c[0]; m_md = 1'b1; exp_start = 5'b00001; end
      3'd3: begin m_md = 1'b0; m_lr = c[0]; m_resp = 8'hA5; action = 1'b0; end
      default: begin m_resp = 8'h5A; action = 1'b0; end
    endcase
  endtask

  // One full command. d: wait-cycle index of the completion strobe
  // (index 0 = first cycle after the start pulse). tx_gap >= 1 cycles
  // between trmt and tx_done; pre_next raises the next command during them.
  task automatic do_cmd(input logic [15:0] c, input int d, input bit wrong_strb,
                        input bit early_strb, input int tx_gap,
                        input bit pre_next, input logic [15:0] nxt);
    logic [4:0] exp_start;
    bit         action;
    bit         is_cal;
    int         trmt_idx;
    accept(c, exp_start, action);
    is_cal = (c[15:13] == 3'd0);

    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    bus.cmd     = 16'($urandom);
    if (action && early_strb) drive_strobe(is_cal, 1'b1, 1'b1);
    #1;
    chk_pulses("start", exp_start);
    check_regs("start");

    if (action) begin
      m_resp   = 8'hA5;
      trmt_idx = d + 2;
`ifdef CMD_TMO_EN
      if (d > TMO_MAX) begin
        m_resp   = 8'h5A;
        trmt_idx = TMO_MAX + 2;
      end
`endif
      for (int k = 0; k <= trmt_idx; k++) begin
        @(negedge clk);
        clear_strobes();
        if (k == d) drive_strobe(is_cal, 1'b1, 1'b1);
        else if (wrong_strb) drive_strobe(is_cal, 1'b0, 1'($urandom_range(0, 1)));
        #1;
        if (k < trmt_idx) chk_pulses("wait", 5'b00000);
        else              chk_pulses("trmt_act", 5'b01000);
      end
    end else begin
      @(negedge clk);
      clear_strobes();
      #1;
      chk_pulses("trmt_direct", 5'b01000);
    end
    check("resp_at_trmt", {24'd0, bus.resp}, {24'd0, m_resp});
    check_regs("trmt");

    for (int g = 0; g < tx_gap; g++) begin
      @(negedge clk);
      clear_strobes();
      if (pre_next) begin
        bus.cmd     = nxt;
        bus.cmd_rdy = 1'b1;
      end
      #1;
      chk_pulses("wait_tx", 5'b00000);
      check("resp_hold", {24'd0, bus.resp}, {24'd0, m_resp});
    end
    @(negedge clk);
    bus.tx_done = 1'b1;
    #1;
    chk_pulses("tx_done", 5'b00000);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      bus.cmd_rdy = 1'b0;
      clear_strobes();
      #1;
      chk_pulses("idle", 5'b00000);
      check_regs("idle");
    end
  endtask

  // Starts c (a heading/move), abandons it mid-wait with a one-cycle reset
  // while nxt is already pending.
  task automatic abort_mid(input logic [15:0] c, input logic [15:0] nxt);
    logic [4:0] exp_start;
    bit         action;
    accept(c, exp_start, action);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    #1;
    chk_pulses("abort_start", exp_start);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk_pulses("abort_wait", 5'b00000);
    end
    @(negedge clk);
    rst         = 1'b1;
    bus.cmd     = nxt;
    bus.cmd_rdy = 1'b1;
    #1;
    chk_pulses("rst_cycle", 5'b00000);
    model_reset();
  endtask

  typedef struct {
    logic [15:0] c;
    int          d;
    bit          wrong;
    bit          early;
    int          gap;
    bit          pre;
  } cmd_t;

  cmd_t tbl[40];

  initial begin
    rst         = 1'b1;
    bus.cmd     = 16'h0000;
    bus.cmd_rdy = 1'b0;
    bus.tx_done = 1'b0;
    clear_strobes();
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    chk_pulses("reset_pulses", 5'b00000);
    check_regs("reset");
    check("reset_resp", {24'd0, bus.resp}, 32'h0000_00A5);

    // CAL, strobe at accept+10; then HDNG with stray cal_done, zero-bubble.
    do_cmd(16'h0000, 8, 1'b0, 1'b1, 2, 1'b1, 16'h23FF);
    do_cmd(16'h23FF, 5, 1'b1, 1'b1, 1, 1'b1, 16'h4002);
    do_cmd(16'h4002, 3, 1'b1, 1'b0, 1, 1'b1, 16'h6001);
    do_cmd(16'h6001, 0, 1'b0, 1'b0, 2, 1'b1, 16'hE000);
    do_cmd(16'hE000, 0, 1'b0, 1'b0, 3, 1'b1, 16'h2123);
    do_cmd(16'h2123, 0, 1'b1, 1'b1, 1, 1'b0, 16'h0000);
    idle_cycles(2);

    abort_mid(16'h4003, 16'h2ABC);
    do_cmd(16'h2ABC, 1, 1'b1, 1'b0, 1, 1'b0, 16'h0000);
    idle_cycles(1);

`ifdef CMD_TMO_EN
    do_cmd(16'h4001, 99, 1'b1, 1'b0, 1, 1'b0, 16'h0000);
    idle_cycles(1);
    do_cmd(16'h4001, TMO_MAX, 1'b0, 1'b0, 1, 1'b0, 16'h0000);
    idle_cycles(1);
    do_cmd(16'h0000, 99, 1'b1, 1'b0, 1, 1'b0, 16'h0000);
    idle_cycles(1);
`endif

    for (int i = 0; i < 40; i++) begin
      tbl[i].c     = {3'($urandom_range(0, 7)), 13'($urandom)};
`ifdef CMD_TMO_EN
      tbl[i].d     = $urandom_range(0, 20);
`else
      tbl[i].d     = $urandom_range(0, 12);
`endif
      tbl[i].wrong = 1'($urandom_range(0, 1));
      tbl[i].early = 1'($urandom_range(0, 1));
      tbl[i].gap   = $urandom_range(1, 3);
      tbl[i].pre   = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 40; i++) begin
      do_cmd(tbl[i].c, tbl[i].d, tbl[i].wrong, tbl[i].early, tbl[i].gap,
             tbl[i].pre && (i < 39), (i < 39) ? tbl[(i < 39) ? i + 1 : i].c : 16'h0000);
      if (!(tbl[i].pre && (i < 39))) idle_cycles($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
